// File: rtl/if_id_reg.sv
// IF/ID pipeline latch with bubble insertion, single-level exception PC capture
// and a sticky HALT state that only reset can clear.
module if_id_reg #(
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] InstrIn,
  input  logic [15:0] IncPCIn,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Exception,
  input  logic        Rti,
  output logic [15:0] InstrOut,
  output logic [15:0] IncPCOut,
  output logic        ValidOut,
  output logic        Halt,
  output logic [15:0] Epc,
  output logic        EpcValid
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t state;
  logic   is_halt_opc;

  assign is_halt_opc = (InstrIn[15:11] == HALT_OPC);
  assign Halt        = (state == HALTED);

  // Fetch -> decode boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      InstrOut <= NOP_INSTR;
      IncPCOut <= 16'h0000;
      ValidOut <= 1'b0;
      Epc      <= 16'h0000;
      EpcValid <= 1'b0;
    end else if (state == HALTED) begin
      InstrOut <= NOP_INSTR;
      ValidOut <= 1'b0;
    end else if (Exception) begin
      InstrOut <= NOP_INSTR;
      IncPCOut <= IncPCIn;
      ValidOut <= 1'b0;
      // Only the first exception is recorded; a nested one leaves Epc alone.
      if (!EpcValid) begin
        Epc      <= IncPCOut;
        EpcValid <= 1'b1;
      end
    end else begin
      if (Rti)
        EpcValid <= 1'b0;
      if (Flush) begin
        InstrOut <= NOP_INSTR;
        IncPCOut <= IncPCIn;
        ValidOut <= 1'b0;
      end else if (!Stall) begin
        InstrOut <= InstrIn;
        IncPCOut <= IncPCIn;
        ValidOut <= 1'b1;
        if (is_halt_opc)
          state <= HALTED;
      end
    end
  end

endmodule
